// File: rtl/hex_display_pio.sv
// ============================================================================
// Module   : hex_display_pio
// Brief    : Avalon-MM slave driving NUM_DIGITS seven-segment digits with
//            per-digit blanking, a blink engine and an atomic add register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_display_pio #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int c_D  = 4 * NUM_DIGITS;
    localparam int c_CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_CW-1:0] c_TERM = c_CW'(BLINK_DIV - 1);
    localparam logic [6:0]      c_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0]      c_ZERO = ACTIVE_LOW ? 7'h40 : 7'h3F;

    localparam logic [2:0] c_ADDR_DATA  = 3'd0;
    localparam logic [2:0] c_ADDR_BLANK = 3'd1;
    localparam logic [2:0] c_ADDR_BLINK = 3'd2;
    localparam logic [2:0] c_ADDR_CTRL  = 3'd3;
    localparam logic [2:0] c_ADDR_ADD   = 3'd4;

    logic [c_D-1:0]          r_data;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [NUM_DIGITS-1:0]   r_blink;
    logic                    r_blink_en;
    logic                    r_phase;
    logic [c_CW-1:0]         r_cnt;
    logic [7*NUM_DIGITS-1:0] r_hex;

    logic                    w_wr;
    logic                    w_ctrl_wr;
    logic [7*NUM_DIGITS-1:0] w_hex;
    logic [31:0]             w_rd;
    logic                    w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_ctrl_wr = w_wr && (address == c_ADDR_CTRL);
    assign w_unused  = ^writedata;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
            logic       w_dark;
            logic [6:0] w_seg;
            assign w_dark = r_blank[k] | (r_blink[k] & r_phase);
            assign w_seg  = f_decode(r_data[4*k +: 4]);
            assign w_hex[7*k +: 7] = w_dark ? c_OFF : (ACTIVE_LOW ? ~w_seg : w_seg);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= '0;
            r_blank    <= '0;
            r_blink    <= '0;
            r_blink_en <= 1'b0;
        end else if (w_wr) begin
            case (address)
                c_ADDR_DATA:  r_data     <= writedata[c_D-1:0];
                c_ADDR_BLANK: r_blank    <= writedata[NUM_DIGITS-1:0];
                c_ADDR_BLINK: r_blink    <= writedata[NUM_DIGITS-1:0];
                c_ADDR_CTRL:  r_blink_en <= writedata[0];
                c_ADDR_ADD:   r_data     <= r_data + writedata[c_D-1:0];
                default: ;
            endcase
        end
    end

    // A CTRL write restarts the blink cycle even if it lands on terminal count.
    always_ff @(posedge clk) begin
        if (reset || w_ctrl_wr || !r_blink_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == c_TERM) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + c_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex <= {NUM_DIGITS{c_ZERO}};
        end else begin
            r_hex <= w_hex;
        end
    end

    always_comb begin
        w_rd = '0;
        case (address)
            c_ADDR_DATA:  w_rd[c_D-1:0]        = r_data;
            c_ADDR_BLANK: w_rd[NUM_DIGITS-1:0] = r_blank;
            c_ADDR_BLINK: w_rd[NUM_DIGITS-1:0] = r_blink;
            c_ADDR_CTRL:  w_rd[1:0]            = {r_phase, r_blink_en};
            default:      w_rd = '0;
        endcase
    end

    assign readdata = w_rd;
    assign hex_out  = r_hex;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_pio.sv
// ============================================================================
// Module   : tb_hex_display_pio
// Brief    : Self-checking bench for hex_display_pio (4 digits, BLINK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_display_pio;

    localparam int c_N   = 4;
    localparam int c_DIV = 4;
    localparam logic [27:0] c_RST_HEX = 28'h8102040;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [27:0] hex_out;

    int n_tests = 0;
    int n_fail  = 0;

    hex_display_pio #(
        .NUM_DIGITS (c_N),
        .BLINK_DIV  (c_DIV),
        .ACTIVE_LOW (1'b1)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .hex_out    (hex_out)
    );

    always #5 clk = ~clk;

    // Reference model: blink phase derived from cycles elapsed since enable.
    logic [6:0]  dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [15:0] m_data;
    logic [3:0]  m_blank;
    logic [3:0]  m_blink;
    logic        m_en;
    int          m_t;
    logic [27:0] m_hex;

    function automatic logic m_phase();
        return ((m_t / c_DIV) % 2) == 1;
    endfunction

    function automatic logic [27:0] m_disp();
        logic [27:0] h;
        for (int k = 0; k < c_N; k++) begin
            if (m_blank[k] || (m_blink[k] && m_phase()))
                h[7*k +: 7] = 7'h7F;
            else
                h[7*k +: 7] = ~dec_tab[m_data[4*k +: 4]];
        end
        return h;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {16'h0, m_data};
            3'd1:    return {28'h0, m_blank};
            3'd2:    return {28'h0, m_blink};
            3'd3:    return {30'h0, m_phase(), m_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_update();
        if (reset) begin
            m_data = '0; m_blank = '0; m_blink = '0; m_en = 1'b0; m_t = 0;
            m_hex = c_RST_HEX;
        end else begin
            m_hex = m_disp();
            if (chipselect && !write_n && address == 3'd3) begin
                m_en = writedata[0];
                m_t  = 0;
            end else if (m_en) begin
                m_t = m_t + 1;
            end else begin
                m_t = 0;
            end
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[15:0];
                    3'd1: m_blank = writedata[3:0];
                    3'd2: m_blink = writedata[3:0];
                    3'd4: m_data = m_data + writedata[15:0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle(input logic [2:0] a);
        chipselect = 1'b0; write_n = 1'b1; address = a; writedata = '0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        bus_idle(a);
    endtask

    typedef struct {
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] exp_rd;
        logic [27:0] exp_hex;
    } vec_t;

    vec_t vecs [11];
    bit   done;

    initial begin
        vecs[0]  = '{3'd0, 32'h0000A5C3, 3'd0, 32'h0000A5C3, {7'h08, 7'h12, 7'h46, 7'h30}};
        vecs[1]  = '{3'd0, 32'h0000FFFE, 3'd0, 32'h0000FFFE, {7'h0E, 7'h0E, 7'h0E, 7'h06}};
        vecs[2]  = '{3'd4, 32'h00000003, 3'd0, 32'h00000001, {7'h40, 7'h40, 7'h40, 7'h79}};
        vecs[3]  = '{3'd4, 32'h00010000, 3'd0, 32'h00000001, {7'h40, 7'h40, 7'h40, 7'h79}};
        vecs[4]  = '{3'd4, 32'h00000000, 3'd4, 32'h00000000, {7'h40, 7'h40, 7'h40, 7'h79}};
        vecs[5]  = '{3'd1, 32'hFFFFFFF8, 3'd1, 32'h00000008, {7'h7F, 7'h40, 7'h40, 7'h79}};
        vecs[6]  = '{3'd6, 32'hFFFFFFFF, 3'd1, 32'h00000008, {7'h7F, 7'h40, 7'h40, 7'h79}};
        vecs[7]  = '{3'd0, 32'h12345678, 3'd0, 32'h00005678, {7'h7F, 7'h02, 7'h78, 7'h00}};
        vecs[8]  = '{3'd2, 32'h000000F2, 3'd2, 32'h00000002, {7'h7F, 7'h02, 7'h78, 7'h00}};
        vecs[9]  = '{3'd3, 32'hFFFFFFFE, 3'd3, 32'h00000000, {7'h7F, 7'h02, 7'h78, 7'h00}};
        vecs[10] = '{3'd1, 32'h00000000, 3'd1, 32'h00000000, {7'h12, 7'h02, 7'h78, 7'h00}};

        reset = 1'b1;
        bus_idle(3'd0);
        tick();
        tick();
        reset = 1'b0;
        check("reset_hex", {4'h0, hex_out}, {4'h0, c_RST_HEX});
        for (int a = 0; a < 8; a++) begin
            address = a[2:0];
            #1;
            check($sformatf("reset_rd%0d", a), readdata, 32'h0);
        end

        for (int i = 0; i < 11; i++) begin
            bus_write(vecs[i].wa, vecs[i].wd);
            address = vecs[i].ra;
            #1;
            check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            tick();
            check($sformatf("vec%0d_hex", i), {4'h0, hex_out}, {4'h0, vecs[i].exp_hex});
        end

        // Blink: digit 1 (nibble 7) alternates, others stay lit.
        bus_write(3'd3, 32'h1);
        address = 3'd3;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("blink_hex%0d", c), {4'h0, hex_out}, {4'h0, m_hex});
            check($sformatf("blink_ctrl%0d", c), readdata, m_read(3'd3));
        end

        // CTRL write on the terminal-count edge while phase = 0.
        done = 0;
        for (int c = 0; c < 16 && !done; c++) begin
            if (m_t % c_DIV == c_DIV - 1 && !m_phase()) done = 1;
            else tick();
        end
        check("tc_found", {31'h0, done}, 32'h1);
        bus_write(3'd3, 32'h1);
        address = 3'd3;
        #1;
        check("tc_ctrl_phase0", readdata, 32'h1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("tc_lit%0d", c), {4'h0, hex_out}, {4'h0, 7'h12, 7'h02, 7'h78, 7'h00});
        end

        // Reset while phase = 1.
        done = 0;
        for (int c = 0; c < 16 && !done; c++) begin
            if (m_phase()) done = 1;
            else tick();
        end
        check("midblink_found", {31'h0, done}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        address = 3'd3;
        #1;
        check("midblink_ctrl", readdata, 32'h0);
        tick();
        check("midblink_hex", {4'h0, hex_out}, {4'h0, c_RST_HEX});

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            reset      = ($urandom_range(0, 59) == 0);
            chipselect = $urandom_range(0, 1);
            write_n    = ($urandom_range(0, 2) == 0);
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if (address == 3'd3 && $urandom_range(0, 3) != 0) writedata[0] = 1'b1;
            #1;
            check("rand_rd", readdata, m_read(address));
            tick();
            check("rand_hex", {4'h0, hex_out}, {4'h0, m_hex});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
